// File: rtl/median7_column_feeder_if.sv
// Pixel-stream in / 7-pixel column out bundle for the 7x7 median column feeder.
// The slave modport is the feeder; the master modport is the pixel source and column sink.
interface median7_column_feeder_if #(
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 9
);
    logic             done_i;
    logic [7:0]       pixel_i;
    logic             done_o;
    logic [7:0]       S1;
    logic [7:0]       S2;
    logic [7:0]       S3;
    logic [7:0]       S4;
    logic [7:0]       S5;
    logic [7:0]       S6;
    logic [7:0]       S7;
    logic [COL_W-1:0] col_o;
    logic [ROW_W-1:0] row_o;
    logic             frame_end_o;

    modport master (
        output done_i, pixel_i,
        input  done_o, S1, S2, S3, S4, S5, S6, S7, col_o, row_o, frame_end_o
    );

    modport slave (
        input  done_i, pixel_i,
        output done_o, S1, S2, S3, S4, S5, S6, S7, col_o, row_o, frame_end_o
    );
endinterface

// File: rtl/median7_column_feeder.sv
// Buffers six previous lines of a raster stream and emits, for every pixel from
// row 6 onward, the 7-pixel vertical column ending at that pixel (oldest line on S1).
module median7_column_feeder #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned COL_W      = 10,
    parameter int unsigned ROW_W      = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    median7_column_feeder_if.slave  bus
);

    localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [7:0] lb_mem [6][IMG_WIDTH];

    logic [AW-1:0]    addr;
    logic [5:0][7:0]  rd;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [6:0][7:0]  s_q, s_d;
    logic [COL_W-1:0] col_out_q, col_out_d;
    logic [ROW_W-1:0] row_out_q, row_out_d;
    logic             done_q, done_d;
    logic             frame_end_q, frame_end_d;

    logic             last_col;
    logic             last_row;

    assign addr     = col_q[AW-1:0];
    assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));

    always_comb begin
        for (int unsigned k = 0; k < 6; k++) begin
            rd[k] = lb_mem[k][addr];
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        s_d         = s_q;
        col_out_d   = col_out_q;
        row_out_d   = row_out_q;
        done_d      = 1'b0;
        frame_end_d = 1'b0;

        if (bus.done_i) begin
            // s index 0 is S1 (oldest line); rd[0] is the newest buffered line
            s_d[6] = bus.pixel_i;
            for (int unsigned k = 0; k < 6; k++) begin
                s_d[5-k] = rd[k];
            end
            col_out_d   = col_q;
            row_out_d   = row_q;
            // Rows 0..5 of every frame are gated so buffers from a prior frame never leak
            done_d      = (row_q >= ROW_W'(6));
            frame_end_d = last_col && last_row;

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Line buffers shift one line deeper at the current column; contents are never reset
    always_ff @(posedge clk) begin
        if (bus.done_i) begin
            lb_mem[0][addr] <= bus.pixel_i;
            for (int unsigned k = 1; k < 6; k++) begin
                lb_mem[k][addr] <= rd[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            s_q         <= '0;
            col_out_q   <= '0;
            row_out_q   <= '0;
            done_q      <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s_q         <= s_d;
            col_out_q   <= col_out_d;
            row_out_q   <= row_out_d;
            done_q      <= done_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign bus.done_o      = done_q;
    assign bus.frame_end_o = frame_end_q;
    assign bus.col_o       = col_out_q;
    assign bus.row_o       = row_out_q;
    assign bus.S1          = s_q[0];
    assign bus.S2          = s_q[1];
    assign bus.S3          = s_q[2];
    assign bus.S4          = s_q[3];
    assign bus.S5          = s_q[4];
    assign bus.S6          = s_q[5];
    assign bus.S7          = s_q[6];

endmodule

// File: tb/tb_median7_column_feeder.sv
// Scoreboard bench for median7_column_feeder on a 4x8 image: stimulus pushes expected
// columns from a frame image model, a negedge monitor pops and compares them.
module tb_median7_column_feeder;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 8;
    localparam int unsigned CW = 2;
    localparam int unsigned RW = 3;

    typedef struct packed {
        logic [55:0] s;
        logic [1:0]  col;
        logic [2:0]  row;
        logic        fe;
    } col_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    median7_column_feeder_if #(.COL_W(CW), .ROW_W(RW)) bus ();

    median7_column_feeder #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (CW),
        .ROW_W     (RW)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    col_t       exp_q[$];
    col_t       log_q[$];
    col_t       ref_q[$];
    logic [7:0] img [H][W];
    int         vectors  = 0;
    int         miscomp  = 0;
    int         n_done   = 0;
    int         n_fe     = 0;
    int         cur_r    = 0;
    int         cur_c    = 0;
    logic       prev_in  = 1'b0;
    col_t       mon_got;
    col_t       mon_exp;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscomp++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic col_t sample();
        return {bus.S1, bus.S2, bus.S3, bus.S4, bus.S5, bus.S6, bus.S7,
                bus.col_o, bus.row_o, bus.frame_end_o};
    endfunction

    function automatic logic [62:0] all_outs();
        return {bus.done_o, bus.frame_end_o, bus.S1, bus.S2, bus.S3, bus.S4,
                bus.S5, bus.S6, bus.S7, bus.col_o, bus.row_o};
    endfunction

    always @(posedge clk) prev_in <= bus.done_i;

    always @(negedge clk) begin
        if (bus.frame_end_o) n_fe++;
        if (bus.done_o) begin
            n_done++;
            mon_got = sample();
            chk("done_after_gap", 64'(prev_in), 64'd1);
            chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("column", 64'(mon_got), 64'(mon_exp));
            end
            log_q.push_back(mon_got);
        end
    end

    function automatic logic [7:0] pixv(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'(r * 16 + c);
            1:       return 8'(8'h80 + r * 16 + c);
            2:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic put(input logic [7:0] px, input int gap);
        col_t e;
        img[cur_r][cur_c] = px;
        if (cur_r >= 6) begin
            for (int k = 0; k < 7; k++) e.s[55-8*k -: 8] = img[cur_r-6+k][cur_c];
            e.col = cur_c[1:0];
            e.row = cur_r[2:0];
            e.fe  = (cur_r == H - 1) && (cur_c == W - 1);
            exp_q.push_back(e);
        end
        bus.done_i  = 1'b1;
        bus.pixel_i = px;
        @(posedge clk);
        #1;
        bus.done_i = 1'b0;
        if (cur_c == W - 1) begin
            cur_c = 0;
            cur_r = (cur_r == H - 1) ? 0 : cur_r + 1;
        end else begin
            cur_c = cur_c + 1;
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int mode, input bit gaps);
        int g;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                g = 0;
                if (gaps) g = (c == W - 1) ? int'($urandom_range(1, 4)) : 1;
                put(pixv(mode, r, c), g);
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int f0;
        bus.done_i  = 1'b0;
        bus.pixel_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(all_outs()), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // continuous frame
        log_q.delete();
        n0 = n_done;
        f0 = n_fe;
        frame(0, 1'b0);
        drain();
        chk("pulses_cont", 64'(n_done - n0), 64'd8);
        chk("fe_cont", 64'(n_fe - f0), 64'd1);
        chk("first_col", 64'(log_q[0]), 64'({56'h00102030405060, 2'd0, 3'd6, 1'b0}));
        chk("col_6_2", 64'(log_q[2]), 64'({56'h02122232425262, 2'd2, 3'd6, 1'b0}));
        chk("col_7_3", 64'(log_q[7]), 64'({56'h13233343536373, 2'd3, 3'd7, 1'b1}));
        ref_q = log_q;

        // same frame with gaps
        log_q.delete();
        n0 = n_done;
        frame(0, 1'b1);
        drain();
        chk("pulses_gap", 64'(n_done - n0), 64'd8);
        for (int i = 0; i < 8; i++) chk("replay", 64'(log_q[i]), 64'(ref_q[i]));

        // back-to-back frames
        log_q.delete();
        n0 = n_done;
        frame(0, 1'b0);
        frame(1, 1'b0);
        drain();
        chk("pulses_b2b", 64'(n_done - n0), 64'd16);
        chk("f2_first_col", 64'(log_q[8]), 64'({56'h8090A0B0C0D0E0, 2'd0, 3'd6, 1'b0}));

        // reset after pixel (6,1)
        for (int i = 0; i < 26; i++) put(pixv(0, cur_r, cur_c), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_now", 64'(all_outs()), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_outputs_held", 64'(all_outs()), 64'd0);
        end
        chk("rst_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur_r = 0;
        cur_c = 0;
        log_q.delete();
        n0 = n_done;
        frame(0, 1'b0);
        drain();
        chk("pulses_rst", 64'(n_done - n0), 64'd8);
        chk("rst_first_col", 64'(log_q[0]), 64'({56'h00102030405060, 2'd0, 3'd6, 1'b0}));

        // constant 0xFF frame then 0x00 frame
        log_q.delete();
        n0 = n_done;
        f0 = n_fe;
        frame(2, 1'b0);
        frame(3, 1'b0);
        drain();
        chk("pulses_const", 64'(n_done - n0), 64'd16);
        chk("fe_const", 64'(n_fe - f0), 64'd2);
        chk("fe_ff_frame", 64'(log_q[7].fe), 64'd1);
        chk("ff_col", 64'(log_q[3].s), 64'hFFFFFFFFFFFFFF);
        for (int i = 8; i < 16; i++) chk("zero_col", 64'(log_q[i].s), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
